// File: rtl/fibonacci_ctrl.sv
// fibonacci_ctrl: valid/ready sequencer that restarts and steps a Fibonacci generator N times and returns F(N).
module fibonacci_ctrl #(
   parameter int DW    = 12,
   parameter int NW    = 5,
   parameter int MAX_N = 18
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [NW-1:0] req_n,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_err,
   output logic          busy,
   output logic          fib_enb,
   output logic          fib_rst,
   input  logic [DW-1:0] fibout
);
   localparam logic [NW-1:0] MAX_I = NW'(MAX_N);
   typedef enum logic [1:0] {IDLE, INIT, RUN, RESP} state_t;
   state_t        state, state_nx;
   logic [NW-1:0] k, k_nx, n, n_nx;
   logic [DW-1:0] data_nx;
   logic          err_nx, live;
   // live keeps req_ready low while reset is asserted without a path from rst to the output
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state    <= IDLE;
         k        <= '0;
         n        <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
         live     <= 1'b0;
      end else begin
         state    <= state_nx;
         k        <= k_nx;
         n        <= n_nx;
         rsp_data <= data_nx;
         rsp_err  <= err_nx;
         live     <= 1'b1;
      end
   always_comb begin
      state_nx  = state;
      k_nx      = k;
      n_nx      = n;
      data_nx   = rsp_data;
      err_nx    = rsp_err;
      req_ready = live && state == IDLE;
      rsp_valid = state == RESP;
      busy      = state != IDLE;
      fib_rst   = state == INIT;
      fib_enb   = state == INIT || (state == RUN && k < n);
      case (state)
         IDLE: if (req_valid && req_ready) begin
            n_nx     = req_n;
            err_nx   = req_n > MAX_I;
            data_nx  = req_n > MAX_I ? '0 : rsp_data;
            state_nx = req_n > MAX_I ? RESP : INIT;
         end
         INIT: begin
            k_nx     = '0;
            state_nx = RUN;
         end
         RUN: begin
            k_nx     = k < n ? k + 1'b1 : k;
            data_nx  = k < n ? rsp_data : fibout;
            state_nx = k < n ? RUN : RESP;
         end
         RESP: state_nx = rsp_ready ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end
endmodule
